moore_pattern_detector: RTL

Parametrised Moore-type serial pattern detector, successor to the fixed two-flip-flop sequence detector. It has a runtime-loadable pattern of PAT_LEN bits and a qualified bit stream. Overlapping or non-overlapping match mode is selectable, and an optional saturating match counter is provided. It sits between a serial bit source (deserialiser/UART bit slicer) and control logic that consumes a one-state-wide detection flag.

---
 rtl/moore_pattern_detector_pkg.sv | 13 +
 rtl/moore_pattern_detector_if.sv | 26 ++
 rtl/moore_pattern_detector_sat_counter.sv | 27 ++
 rtl/moore_pattern_detector.sv | 84 ++++++++
 4 files changed

// File: rtl/moore_pattern_detector_pkg.sv
// Shared types and defaults for moore_pattern_detector.
package moore_pattern_detector_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    HUNT  = 2'd1,
    MATCH = 2'd2
  } state_e;

  localparam int PAT_LEN_DEF = 4;
  localparam int CNT_W_DEF   = 8;

endpackage

// File: rtl/moore_pattern_detector_if.sv
// Serial stream, pattern control and detect/count bus for moore_pattern_detector.
interface moore_pattern_detector_if
  import moore_pattern_detector_pkg::*;
#(
  parameter int PAT_LEN = PAT_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
);
  logic               x;
  logic               valid;
  logic               load;
  logic [PAT_LEN-1:0] pattern;
  logic               overlap;
  logic               clear;
  logic               y;
  logic [CNT_W-1:0]   match_count;

  modport master (
    output x, valid, load, pattern, overlap, clear,
    input  y, match_count
  );

  modport slave (
    input  x, valid, load, pattern, overlap, clear,
    output y, match_count
  );
endinterface

// File: rtl/moore_pattern_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != '1))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign q = cnt_q;
endmodule

// File: rtl/moore_pattern_detector.sv
// Moore serial pattern detector with loadable pattern and overlap select.
// Match counter is built only when MATCH_COUNT_EN is defined.
module moore_pattern_detector
  import moore_pattern_detector_pkg::*;
#(
  parameter int PAT_LEN = PAT_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  moore_pattern_detector_if.slave   bus
);
  localparam int FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

  state_e             state_q, state_d;
  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [PAT_LEN-1:0] hist_q, hist_d, hist_shift;
  logic [FILL_W-1:0]  fill_q, fill_d, fill_inc;
  logic               match_entry;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= FILL;
      pat_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
    end
  end

  // Next state is decided from the post-shift history and fill level.
  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    match_entry = 1'b0;
    hist_shift  = {hist_q[PAT_LEN-2:0], bus.x};
    fill_inc    = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
    if (bus.load) begin
      pat_d   = bus.pattern;
      hist_d  = '0;
      fill_d  = '0;
      state_d = FILL;
    end else if (bus.valid) begin
      hist_d = hist_shift;
      if ((fill_inc == FILL_FULL) && (hist_shift == pat_q)) begin
        state_d     = MATCH;
        match_entry = 1'b1;
        fill_d      = bus.overlap ? FILL_FULL : '0;
      end else if (fill_inc == FILL_FULL) begin
        state_d = HUNT;
        fill_d  = FILL_FULL;
      end else begin
        state_d = FILL;
        fill_d  = fill_inc;
      end
    end
  end

  always_comb begin
    bus.y = (state_q == MATCH);
  end

`ifdef MATCH_COUNT_EN
  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (match_entry),
    .clr   (bus.clear),
    .q     (bus.match_count)
  );
`else
  logic [1:0] unused_cnt_inputs;
  assign unused_cnt_inputs = {bus.clear, match_entry};
  assign bus.match_count   = '0;
`endif

endmodule
